// File: rtl/haar_lift_seq_if.sv
// Handshake bundle between the Haar lifting frame sequencer and its
// pixel RAM, lifting unit and result buffers.
interface haar_lift_seq_if #(
    parameter int AW = 12
);
    logic          go;
    logic          stall;
    logic          rd_en;
    logic [AW-1:0] rd_addr_a;
    logic [AW-1:0] rd_addr_b;
    logic          hl_start;
    logic          hl_data_occur;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          busy;
    logic          done;
    logic          err;

    // Environment side: frame control, back-pressure and lifting-unit feedback.
    modport master (
        output go, stall, hl_data_occur,
        input  rd_en, rd_addr_a, rd_addr_b, hl_start, wr_en, wr_addr,
               busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  go, stall, hl_data_occur,
        output rd_en, rd_addr_a, rd_addr_b, hl_start, wr_en, wr_addr,
               busy, done, err
    );
endinterface

// File: rtl/haar_lift_seq.sv
// Frame-level sequencer for a single-level Haar lifting datapath.
// Scans the image two rows at a time, issuing one vertical pixel pair per
// cycle, and tracks each issue through a 2-stage pipeline (RAM read, lifting
// unit) to generate result-buffer writes and an alignment error flag.
module haar_lift_seq #(
    parameter int IMG_W = 4,
    parameter int IMG_H = 4,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             reset,
    haar_lift_seq_if.slave   bus
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [AW-1:0] ZERO   = AW'(0);
    localparam logic [AW-1:0] ONE    = AW'(1);
    localparam logic [AW-1:0] W_A    = AW'(IMG_W);
    // Moving from (2r, W-1) to (2r+2, 0) skips the odd row: +W+1.
    localparam logic [AW-1:0] W_STEP = AW'(IMG_W + 1);
    localparam logic [AW-1:0] C_LAST = AW'(IMG_W - 1);
    localparam logic [AW-1:0] R_LAST = AW'(IMG_H / 2 - 1);

    state_t        state_q, state_d;
    logic [AW-1:0] c_q, c_d;
    logic [AW-1:0] r_q, r_d;
    logic [AW-1:0] a_q, a_d;       // upper pixel address 2r*W + c
    logic [AW-1:0] b_q, b_d;       // lower pixel address (2r+1)*W + c
    logic [AW-1:0] res_q, res_d;   // result address r*W + c (linear in issue order)
    logic          v1_q, v1_d;     // stage 1: RAM data valid / hl_start
    logic [AW-1:0] a1_q, a1_d;
    logic          v2_q, v2_d;     // stage 2: result expected / wr_en
    logic [AW-1:0] a2_q, a2_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic          issue_s;
    logic          last_s;
    logic          fetch_s;

    // Issue qualification: a pair goes out in FETCH whenever the sink is not stalling.
    always_comb begin
        fetch_s = (state_q == S_FETCH);
        issue_s = fetch_s && !bus.stall;
        last_s  = issue_s && (c_q == C_LAST) && (r_q == R_LAST);
    end

    // Next-state, scan counters, issue pipeline and status flags.
    always_comb begin
        state_d = state_q;
        c_d     = c_q;
        r_d     = r_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        err_d   = err_q | (bus.hl_data_occur != v2_q);

        case (state_q)
            S_IDLE: begin
                if (bus.go) begin
                    state_d = S_FETCH;
                    c_d     = ZERO;
                    r_d     = ZERO;
                    a_d     = ZERO;
                    b_d     = W_A;
                    res_d   = ZERO;
                    err_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                if (issue_s) begin
                    res_d = res_q + ONE;
                    if (c_q == C_LAST) begin
                        c_d = ZERO;
                        r_d = r_q + ONE;
                        a_d = a_q + W_STEP;
                        b_d = b_q + W_STEP;
                    end else begin
                        c_d = c_q + ONE;
                        a_d = a_q + ONE;
                        b_d = b_q + ONE;
                    end
                    if (last_s) begin
                        state_d = S_DRAIN;
                    end else begin
                        state_d = S_FETCH;
                    end
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_DRAIN: begin
                // Stage 1 empty now means stage 2 is empty once DONE is entered.
                if (!v1_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        v1_d   = issue_s;
        a1_d   = issue_s ? res_q : ZERO;
        v2_d   = v1_q;
        a2_d   = v1_q ? a1_q : ZERO;
        busy_d = (state_d == S_FETCH) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // State and pipeline registers; reset discards anything in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            c_q     <= ZERO;
            r_q     <= ZERO;
            a_q     <= ZERO;
            b_q     <= ZERO;
            res_q   <= ZERO;
            v1_q    <= 1'b0;
            a1_q    <= ZERO;
            v2_q    <= 1'b0;
            a2_q    <= ZERO;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            r_q     <= r_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            v1_q    <= v1_d;
            a1_q    <= a1_d;
            v2_q    <= v2_d;
            a2_q    <= a2_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    // Output drive: read strobe follows stall within the cycle; everything else is a flop.
    always_comb begin
        bus.rd_en     = issue_s;
        bus.rd_addr_a = fetch_s ? a_q : ZERO;
        bus.rd_addr_b = fetch_s ? b_q : ZERO;
        bus.hl_start  = v1_q;
        bus.wr_en     = v2_q;
        bus.wr_addr   = a2_q;
        bus.busy      = busy_q;
        bus.done      = done_q;
        bus.err       = err_q;
    end
endmodule

// File: tb/tb_haar_lift_seq.sv
// Directed bench for haar_lift_seq: per-cycle expectation tables for the
// 4x4 default frame, stall, alignment error, ignored go and a 3x2 frame,
// plus a hand-written asynchronous reset sequence.
module tb_haar_lift_seq;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    haar_lift_seq_if #(.AW(12)) bus ();
    haar_lift_seq_if #(.AW(12)) bus2 ();

    haar_lift_seq #(.IMG_W(4), .IMG_H(4), .AW(12)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    haar_lift_seq #(.IMG_W(3), .IMG_H(2), .AW(12)) dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (bus2.slave)
    );

    // Ideal lifting-unit models: result valid one cycle after hl_start.
    logic occ1_q, occ2_q, drop1;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            occ1_q <= 1'b0;
            occ2_q <= 1'b0;
        end else begin
            occ1_q <= bus.hl_start;
            occ2_q <= bus2.hl_start;
        end
    end
    assign bus.hl_data_occur  = occ1_q & ~drop1;
    assign bus2.hl_data_occur = occ2_q;

    typedef struct {
        logic        go;
        logic        stall;
        logic        drop;
        logic        rd;
        logic [11:0] a;
        logic [11:0] b;
        logic        hs;
        logic        we;
        logic [11:0] wa;
        logic        busy;
        logic        done;
        int          err;   // 0/1 expected, 2 = not compared
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic go, logic stall, logic drop, logic rd,
                                int a, int b, logic hs, logic we, int wa,
                                logic busy, logic done, int err);
        vec_t v;
        v.go = go; v.stall = stall; v.drop = drop; v.rd = rd;
        v.a = 12'(a); v.b = 12'(b); v.hs = hs; v.we = we; v.wa = 12'(wa);
        v.busy = busy; v.done = done; v.err = err;
        return v;
    endfunction

    task automatic chk(string name, int cyc, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
        end
    endtask

    // Apply tbl cycle by cycle to dut (sel=0) or dut2 (sel=1) and compare.
    task automatic run_table(string tag, int sel);
        logic rd, hs, we, busy, done, err;
        logic [11:0] a, b, wa;
        for (int i = 0; i < tbl.size(); i++) begin
            if (sel == 0) begin
                bus.go = tbl[i].go; bus.stall = tbl[i].stall; drop1 = tbl[i].drop;
            end else begin
                bus2.go = tbl[i].go; bus2.stall = tbl[i].stall;
            end
            @(negedge clk);
            if (sel == 0) begin
                rd = bus.rd_en; a = bus.rd_addr_a; b = bus.rd_addr_b; hs = bus.hl_start;
                we = bus.wr_en; wa = bus.wr_addr; busy = bus.busy; done = bus.done; err = bus.err;
            end else begin
                rd = bus2.rd_en; a = bus2.rd_addr_a; b = bus2.rd_addr_b; hs = bus2.hl_start;
                we = bus2.wr_en; wa = bus2.wr_addr; busy = bus2.busy; done = bus2.done; err = bus2.err;
            end
            chk({tag, " rd_en"}, i, 32'(rd), 32'(tbl[i].rd));
            if (tbl[i].rd) begin
                chk({tag, " rd_addr_a"}, i, 32'(a), 32'(tbl[i].a));
                chk({tag, " rd_addr_b"}, i, 32'(b), 32'(tbl[i].b));
            end
            chk({tag, " hl_start"}, i, 32'(hs), 32'(tbl[i].hs));
            chk({tag, " wr_en"}, i, 32'(we), 32'(tbl[i].we));
            if (tbl[i].we) chk({tag, " wr_addr"}, i, 32'(wa), 32'(tbl[i].wa));
            chk({tag, " busy"}, i, 32'(busy), 32'(tbl[i].busy));
            chk({tag, " done"}, i, 32'(done), 32'(tbl[i].done));
            if (tbl[i].err != 2) chk({tag, " err"}, i, 32'(err), 32'(tbl[i].err));
            @(posedge clk);
            #1;
        end
        bus.go = 1'b0; bus.stall = 1'b0; drop1 = 1'b0;
        bus2.go = 1'b0; bus2.stall = 1'b0;
    endtask

    // Default 4x4 frame, go in cycle 0, no stall; err column and go/drop overrides are applied per test.
    task automatic load_default(int err_from, logic drop5, logic go_extra);
        tbl.delete();
        tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, err_from == 0 ? 1 : 0));
        tbl.push_back(mk(0, 0, 0, 1,  0,  4, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1,  5, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  2,  6, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(go_extra, 0, 0, 1,  3,  7, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, drop5, 1,  8, 12, 1, 1, 2, 1, 0, drop5 ? 2 : 0));
        for (int i = 6; i <= 8; i++)
            tbl.push_back(mk(0, 0, 0, 1, i + 3, i + 7, 1, 1, i - 3, 1, 0, drop5 ? 1 : 0));
        tbl.push_back(mk(go_extra, 0, 0, 0,  0,  0, 1, 1, 6, 1, 0, drop5 ? 1 : 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 1, 7, 1, 0, drop5 ? 1 : 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 1, drop5 ? 1 : 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, drop5 ? 1 : 0));
    endtask

    initial begin
        int writes;
        bit seen_done;
        bus.go = 1'b0; bus.stall = 1'b0; drop1 = 1'b0;
        bus2.go = 1'b0; bus2.stall = 1'b0;

        // Reset state.
        #2;
        chk("reset rd_en", 0, 32'(bus.rd_en), 32'd0);
        chk("reset wr_en", 0, 32'(bus.wr_en), 32'd0);
        chk("reset busy", 0, 32'(bus.busy), 32'd0);
        chk("reset err", 0, 32'(bus.err), 32'd0);
        chk("reset hl_start", 0, 32'(bus.hl_start), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        load_default(-1, 1'b0, 1'b0);
        run_table("default", 0);

        // Stall in cycles 3 and 4.
        tbl.delete();
        tbl.push_back(mk(1, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  0,  4, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  1,  5, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  2,  6, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  2,  6, 0, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  2,  6, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  3,  7, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  8, 12, 1, 1, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1,  9, 13, 1, 1, 3, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 10, 14, 1, 1, 4, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 11, 15, 1, 1, 5, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0, 1, 1, 6, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 1, 7, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0,  0,  0, 0, 0, 0, 0, 0, 0));
        run_table("stall", 0);

        // Third result dropped by the lifting unit: err sticks through done.
        load_default(-1, 1'b1, 1'b0);
        run_table("drop", 0);

        // Extra go in cycles 4 and 9 is ignored; err from the previous frame clears.
        load_default(0, 1'b0, 1'b1);
        tbl[9].go = 1'b1;
        tbl[4].go = 1'b1;
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_table("go_ignored", 0);

        // Asynchronous reset in the middle of cycle 5.
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2 rst = 1'b1;
        #1;
        chk("async rst rd_en", 5, 32'(bus.rd_en), 32'd0);
        chk("async rst rd_addr_a", 5, 32'(bus.rd_addr_a), 32'd0);
        chk("async rst rd_addr_b", 5, 32'(bus.rd_addr_b), 32'd0);
        chk("async rst hl_start", 5, 32'(bus.hl_start), 32'd0);
        chk("async rst wr_en", 5, 32'(bus.wr_en), 32'd0);
        chk("async rst wr_addr", 5, 32'(bus.wr_addr), 32'd0);
        chk("async rst busy", 5, 32'(bus.busy), 32'd0);
        chk("async rst done", 5, 32'(bus.done), 32'd0);
        chk("async rst err", 5, 32'(bus.err), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        writes = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.wr_en) writes++;
            @(posedge clk); #1;
        end
        chk("post-reset writes", 0, 32'(writes), 32'd0);
        bus.go = 1'b1;
        @(posedge clk); #1;
        bus.go = 1'b0;
        @(negedge clk);
        chk("restart rd_en", 1, 32'(bus.rd_en), 32'd1);
        chk("restart rd_addr_a", 1, 32'(bus.rd_addr_a), 32'd0);
        chk("restart rd_addr_b", 1, 32'(bus.rd_addr_b), 32'd4);
        writes = 0;
        seen_done = 1'b0;
        for (int i = 0; i < 30 && !seen_done; i++) begin
            if (bus.wr_en) writes++;
            if (bus.done) seen_done = 1'b1;
            @(negedge clk);
        end
        chk("restart done seen", 0, 32'(seen_done), 32'd1);
        chk("restart writes", 0, 32'(writes), 32'd8);
        chk("restart err", 0, 32'(bus.err), 32'd0);
        @(posedge clk); #1;

        // 3x2 image on the second instance.
        tbl.delete();
        tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 3, 0, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 4, 1, 0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 5, 1, 1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        run_table("w3h2", 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
